// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider with 50% duty for any divisor 2..2^WIDTH-1.
// Odd divisors gain half-cycle resolution from a falling-edge copy of the phase flop.
module clk_div_prog #(
  parameter int WIDTH     = 8,
  parameter int DIV_RESET = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             load_err,
  output logic [WIDTH-1:0] div_cur,
  output logic             tick,
  output logic             clk_out
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_C    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DIV_RST_C = DIV_RESET[WIDTH-1:0];

  // ceil(d/2) at WIDTH+1 bits so d = 2^WIDTH-1 cannot overflow
  function automatic logic [WIDTH:0] half_thr(input logic [WIDTH-1:0] d);
    logic [WIDTH:0] sum;
    sum = {1'b0, d} + {{WIDTH{1'b0}}, 1'b1};
    return {1'b0, sum[WIDTH:1]};
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] cnt_inc_s;
  logic             q_p_r, q_p_s;
  logic             q_n_r;
  logic             tick_r, tick_s;
  logic [WIDTH-1:0] div_cur_r, div_cur_s;
  logic             odd_r, odd_s;
  logic [WIDTH-1:0] pend_div_r, pend_div_s;
  logic             pend_valid_r, pend_valid_s;
  logic             div_ack_r, div_ack_s;
  logic             load_err_r, load_err_s;
  logic             apply_s;
  logic             legal_s;

  // Next-state, counter, phase and divisor-handshake logic
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    q_p_s        = q_p_r;
    tick_s       = 1'b0;
    apply_s      = 1'b0;
    cnt_inc_s    = cnt_r + ONE_C;
    legal_s      = |div_val[WIDTH-1:1];
    case (state_r)
      IDLE: begin
        if (en) begin
          state_s = RUN;
          cnt_s   = ZERO_C;
          q_p_s   = 1'b1;
          tick_s  = 1'b1;
          apply_s = pend_valid_r;
        end else begin
          cnt_s = ZERO_C;
          q_p_s = 1'b0;
        end
      end
      RUN: begin
        if (cnt_r == (div_cur_r - ONE_C)) begin
          if (en) begin
            cnt_s   = ZERO_C;
            q_p_s   = 1'b1;
            tick_s  = 1'b1;
            apply_s = pend_valid_r;
          end else begin
            state_s = IDLE;
            cnt_s   = ZERO_C;
            q_p_s   = 1'b0;
          end
        end else begin
          cnt_s = cnt_inc_s;
          q_p_s = ({1'b0, cnt_inc_s} < half_thr(div_cur_r));
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = ZERO_C;
        q_p_s   = 1'b0;
      end
    endcase

    // The pending value seen by apply is the one registered before this edge,
    // so a load on the boundary cycle waits for the next boundary.
    if (apply_s) begin
      div_cur_s = pend_div_r;
      odd_s     = pend_div_r[0];
    end else begin
      div_cur_s = div_cur_r;
      odd_s     = odd_r;
    end

    if (div_load && legal_s) begin
      pend_div_s   = div_val;
      pend_valid_s = 1'b1;
    end else if (apply_s) begin
      pend_div_s   = pend_div_r;
      pend_valid_s = 1'b0;
    end else begin
      pend_div_s   = pend_div_r;
      pend_valid_s = pend_valid_r;
    end

    div_ack_s  = apply_s;
    load_err_s = div_load && !legal_s;
  end

  // Rising-edge state and output registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= ZERO_C;
      q_p_r        <= 1'b0;
      tick_r       <= 1'b0;
      div_cur_r    <= DIV_RST_C;
      odd_r        <= DIV_RST_C[0];
      pend_div_r   <= DIV_RST_C;
      pend_valid_r <= 1'b0;
      div_ack_r    <= 1'b0;
      load_err_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      q_p_r        <= q_p_s;
      tick_r       <= tick_s;
      div_cur_r    <= div_cur_s;
      odd_r        <= odd_s;
      pend_div_r   <= pend_div_s;
      pend_valid_r <= pend_valid_s;
      div_ack_r    <= div_ack_s;
      load_err_r   <= load_err_s;
    end
  end

  // Falling-edge copy of the phase flop for the extra half cycle on odd divisors
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      q_n_r <= 1'b0;
    end else begin
      q_n_r <= q_p_r;
    end
  end

  // odd_r only changes at a period start, when both q_p_r and q_n_r are low
  assign clk_out  = odd_r ? (q_p_r & q_n_r) : q_p_r;
  assign tick     = tick_r;
  assign div_cur  = div_cur_r;
  assign div_ack  = div_ack_r;
  assign load_err = load_err_r;

endmodule
